// File: rtl/operand_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : operand_forward_unit
// Brief    : EX-stage operand bypass with retired-write history, load-use
//            stall generation and saturating performance counters.
// Revision : 1.0
// ============================================================================
module operand_forward_unit #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_SRC    = 2,
    parameter int HIST_DEPTH = 2,
    parameter int CNT_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*ADDR_W-1:0] Src_Addr,
    input  logic [NUM_SRC*DATA_W-1:0] Data_ID,
    input  logic                      MEM_RegWrite,
    input  logic [ADDR_W-1:0]         MEM_Rd,
    input  logic [DATA_W-1:0]         MEM_Data,
    input  logic                      MEM_IsLoad,
    input  logic                      MEM_LoadValid,
    input  logic                      WB_RegWrite,
    input  logic [ADDR_W-1:0]         WB_Rd,
    input  logic [DATA_W-1:0]         WB_Data,
    input  logic                      Pipe_Advance,
    output logic [NUM_SRC*DATA_W-1:0] Out,
    output logic [NUM_SRC*2-1:0]      Sel,
    output logic                      Stall,
    output logic [CNT_W-1:0]          Stall_Count,
    output logic [CNT_W-1:0]          Fwd_Count
);

    localparam logic [1:0]       c_sel_id   = 2'b00;
    localparam logic [1:0]       c_sel_mem  = 2'b01;
    localparam logic [1:0]       c_sel_wb   = 2'b10;
    localparam logic [1:0]       c_sel_hist = 2'b11;
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic              r_hist_vld  [HIST_DEPTH];
    logic [ADDR_W-1:0] r_hist_rd   [HIST_DEPTH];
    logic [DATA_W-1:0] r_hist_data [HIST_DEPTH];

    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_fwd_cnt;

    logic [NUM_SRC-1:0] w_stall_vec;
    logic [NUM_SRC-1:0] w_fwd_vec;

    // Entry 0 is the newest retirement; a non-writing WB still shifts in a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < HIST_DEPTH; k++) begin
                r_hist_vld[k]  <= 1'b0;
                r_hist_rd[k]   <= '0;
                r_hist_data[k] <= '0;
            end
        end else if (Pipe_Advance) begin
            for (int k = HIST_DEPTH - 1; k > 0; k--) begin
                r_hist_vld[k]  <= r_hist_vld[k-1];
                r_hist_rd[k]   <= r_hist_rd[k-1];
                r_hist_data[k] <= r_hist_data[k-1];
            end
            r_hist_vld[0]  <= WB_RegWrite && (WB_Rd != '0);
            r_hist_rd[0]   <= WB_Rd;
            r_hist_data[0] <= WB_Data;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_out;
        logic [1:0]        w_sel;
        logic              w_ld_stall;

        assign w_addr = Src_Addr[i*ADDR_W +: ADDR_W];

        // Candidates are applied oldest-first so each younger match overrides.
        always_comb begin
            w_sel      = c_sel_id;
            w_out      = Data_ID[i*DATA_W +: DATA_W];
            w_ld_stall = 1'b0;
            if (w_addr != '0) begin
                for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
                    if (r_hist_vld[k] && (r_hist_rd[k] == w_addr)) begin
                        w_sel = c_sel_hist;
                        w_out = r_hist_data[k];
                    end
                end
                if (WB_RegWrite && (WB_Rd == w_addr)) begin
                    w_sel = c_sel_wb;
                    w_out = WB_Data;
                end
                if (MEM_RegWrite && (MEM_Rd == w_addr)) begin
                    w_sel      = c_sel_mem;
                    w_out      = MEM_Data;
                    w_ld_stall = MEM_IsLoad && !MEM_LoadValid;
                end
            end
        end

        assign Out[i*DATA_W +: DATA_W] = w_out;
        assign Sel[i*2 +: 2]           = w_sel;
        assign w_stall_vec[i]          = w_ld_stall;
        assign w_fwd_vec[i]            = (w_sel != c_sel_id);
    end

    assign Stall = |w_stall_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (Stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (Pipe_Advance && !Stall && (|w_fwd_vec) && (r_fwd_cnt != c_cnt_max)) begin
                r_fwd_cnt <= r_fwd_cnt + c_cnt_one;
            end
        end
    end

    assign Stall_Count = r_stall_cnt;
    assign Fwd_Count   = r_fwd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_operand_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_forward_unit
// Brief    : Directed and random checks of operand_forward_unit against a
//            list-search reference model.
// Revision : 1.0
// ============================================================================
module tb_operand_forward_unit;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int NUM_SRC    = 2;
    localparam int HIST_DEPTH = 2;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [NUM_SRC*DATA_W-1:0] data_id;
    logic                      mem_we, mem_ld, mem_lv, wb_we, adv;
    logic [ADDR_W-1:0]         mem_rd, wb_rd;
    logic [DATA_W-1:0]         mem_data, wb_data;
    logic [NUM_SRC*DATA_W-1:0] out;
    logic [NUM_SRC*2-1:0]      sel;
    logic                      stall;
    logic [CNT_W-1:0]          stall_cnt, fwd_cnt;

    operand_forward_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC),
        .HIST_DEPTH(HIST_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .Src_Addr(src_addr), .Data_ID(data_id),
        .MEM_RegWrite(mem_we), .MEM_Rd(mem_rd), .MEM_Data(mem_data),
        .MEM_IsLoad(mem_ld), .MEM_LoadValid(mem_lv),
        .WB_RegWrite(wb_we), .WB_Rd(wb_rd), .WB_Data(wb_data),
        .Pipe_Advance(adv), .Out(out), .Sel(sel), .Stall(stall),
        .Stall_Count(stall_cnt), .Fwd_Count(fwd_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: history is a list, newest first; counters are ints.
    typedef struct {
        bit        v;
        bit [4:0]  rd;
        bit [31:0] d;
    } ent_t;
    ent_t hist[$];
    int   m_sc, m_fc;
    bit [31:0] m_out [NUM_SRC];
    int        m_sel [NUM_SRC];
    bit        m_stall;

    function automatic void model_reset();
        ent_t e;
        e = '{v: 1'b0, rd: 5'd0, d: 32'd0};
        hist.delete();
        for (int k = 0; k < HIST_DEPTH; k++) hist.push_back(e);
        m_sc = 0;
        m_fc = 0;
    endfunction

    function automatic void model_eval();
        m_stall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            bit [4:0] a;
            a = src_addr[i*ADDR_W +: ADDR_W];
            m_sel[i] = 0;
            m_out[i] = data_id[i*DATA_W +: DATA_W];
            if (a != 0) begin
                if (mem_we && mem_rd == a) begin
                    m_sel[i] = 1;
                    m_out[i] = mem_data;
                    if (mem_ld && !mem_lv) m_stall = 1'b1;
                end else if (wb_we && wb_rd == a) begin
                    m_sel[i] = 2;
                    m_out[i] = wb_data;
                end else begin
                    foreach (hist[k]) begin
                        if (m_sel[i] == 0 && hist[k].v && hist[k].rd == a) begin
                            m_sel[i] = 3;
                            m_out[i] = hist[k].d;
                        end
                    end
                end
            end
        end
    endfunction

    function automatic void model_edge();
        bit any;
        ent_t e;
        model_eval();
        any = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) if (m_sel[i] != 0) any = 1'b1;
        if (m_stall && m_sc < CNT_MAX) m_sc++;
        if (adv && !m_stall && any && m_fc < CNT_MAX) m_fc++;
        if (adv) begin
            e = '{v: wb_we && wb_rd != 0, rd: wb_rd, d: wb_data};
            hist.push_front(e);
            void'(hist.pop_back());
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        model_eval();
        for (int i = 0; i < NUM_SRC; i++) begin
            chk({tag, "_out"}, 64'(out[i*DATA_W +: DATA_W]), 64'(m_out[i]));
            chk({tag, "_sel"}, 64'(sel[i*2 +: 2]), 64'(m_sel[i]));
        end
        chk({tag, "_stall"}, 64'(stall), 64'(m_stall));
        chk({tag, "_scnt"}, 64'(stall_cnt), 64'(m_sc));
        chk({tag, "_fcnt"}, 64'(fwd_cnt), 64'(m_fc));
    endtask

    // Inputs are driven 1 time unit after a rising edge; checks land mid-cycle.
    task automatic cycle(input string tag);
        #2;
        check_all(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        src_addr = '0; data_id = '0;
        mem_we = 0; mem_rd = 0; mem_data = 0; mem_ld = 0; mem_lv = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; adv = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // No writes pending: both operands come from ID.
        src_addr = {5'd3, 5'd5};
        data_id  = {32'h22, 32'h11};
        #2;
        chk("id_out0", 64'(out[31:0]), 64'h11);
        chk("id_out1", 64'(out[63:32]), 64'h22);
        chk("id_sel", 64'(sel), 64'h0);
        cycle("id");

        // MEM beats WB for the same register; x0 never forwards.
        mem_we = 1; mem_rd = 5'd3; mem_data = 32'hAAAA;
        wb_we = 1;  wb_rd = 5'd3;  wb_data = 32'hBBBB;
        src_addr = {5'd3, 5'd3};
        #2;
        chk("mem_pri_out0", 64'(out[31:0]), 64'hAAAA);
        chk("mem_pri_sel0", 64'(sel[1:0]), 64'h1);
        cycle("mem_pri");
        src_addr = {5'd3, 5'd0};
        #2;
        chk("x0_out0", 64'(out[31:0]), 64'h11);
        chk("x0_sel0", 64'(sel[1:0]), 64'h0);
        cycle("x0");

        // x7 retires, ages through the history and falls off the end.
        idle_inputs();
        wb_we = 1; wb_rd = 5'd7; wb_data = 32'hC0DE; adv = 1;
        cycle("push7");
        wb_we = 0; wb_rd = 0; wb_data = 0;
        cycle("bubble1");
        adv = 0; src_addr = {5'd0, 5'd7};
        #2;
        chk("hist_out0", 64'(out[31:0]), 64'hC0DE);
        chk("hist_sel0", 64'(sel[1:0]), 64'h3);
        cycle("hist");
        adv = 1;
        cycle("bubble2");
        adv = 0;
        #2;
        chk("aged_out0", 64'(out[31:0]), 64'h0);
        chk("aged_sel0", 64'(sel[1:0]), 64'h0);
        cycle("aged");

        // Load-use: two stalled cycles, then the load data arrives.
        mem_we = 1; mem_rd = 5'd9; mem_ld = 1; mem_lv = 0; mem_data = 32'hDEAD;
        src_addr = {5'd0, 5'd9};
        #2;
        chk("lu_stall", 64'(stall), 64'h1);
        chk("lu_sel0", 64'(sel[1:0]), 64'h1);
        cycle("lu1");
        cycle("lu2");
        mem_lv = 1; mem_data = 32'h55; adv = 1;
        #2;
        chk("lu_done_stall", 64'(stall), 64'h0);
        chk("lu_done_out0", 64'(out[31:0]), 64'h55);
        chk("lu_done_scnt", 64'(stall_cnt), 64'h2);
        cycle("lu_done");

        // Stall counter saturation.
        mem_lv = 0; adv = 0;
        for (int c = 0; c < 16; c++) cycle("sat");
        #2;
        chk("sat_scnt", 64'(stall_cnt), 64'(CNT_MAX));
        cycle("sat_hold");

        // Async reset in the middle of a stall with live history.
        mem_rd = 5'd9; src_addr = {5'd9, 5'd12}; mem_lv = 0;
        wb_we = 1; wb_rd = 5'd12; wb_data = 32'h1234; adv = 1;
        data_id = {32'h77, 32'h66};
        cycle("push12");
        wb_we = 0; adv = 0;
        #2;
        chk("pre_rst_sel0", 64'(sel[1:0]), 64'h3);
        chk("pre_rst_stall", 64'(stall), 64'h1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_scnt", 64'(stall_cnt), 64'h0);
        chk("rst_out0", 64'(out[31:0]), 64'h66);
        chk("rst_sel0", 64'(sel[1:0]), 64'h0);
        check_all("in_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("post_rst");

        // Random traffic over a small register range to force collisions.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                src_addr[i*ADDR_W +: ADDR_W] = 5'($urandom_range(0, 7));
                data_id[i*DATA_W +: DATA_W]  = $urandom;
            end
            mem_we = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
            mem_ld = 1'($urandom); mem_lv = ($urandom_range(0, 3) != 0);
            wb_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
            adv = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
